// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access unit: transfer sizes, FSM states, alignment masks.
// Purely declarative; no latency and no flow control of its own.
// Used by the controller FSM and by the lane-steering datapath.
`timescale 1ns/1ps
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [1:0] SZ_DOUBLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Low address bits that must be zero for a naturally aligned access of this size.
    function automatic int unsigned align_mask(input logic [1:0] size, input int unsigned bytes);
        case (size)
            SZ_BYTE: return 0;
            SZ_HALF: return 1;
            SZ_WORD: return bytes - 1;
            default: return 2 * bytes - 1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Little-endian lane steering: store replication, byte enables, load extract and extend.
// Purely combinational, zero latency.
// No flow control; the FSM decides when its outputs are captured.
`timescale 1ns/1ps
module mem_lane_steer
    import mem_access_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int BE_W   = DATA_W / 8,
    localparam int OFF_W  = $clog2(BE_W)
) (
    input  logic [1:0]        size,
    input  logic              is_signed,
    input  logic [OFF_W-1:0]  offset,
    input  logic [DATA_W-1:0] st_data,
    input  logic [DATA_W-1:0] ld_data,
    output logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] st_lanes,
    output logic [DATA_W-1:0] ld_ext
);

    logic [OFF_W+2:0] bit_base;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;

    assign bit_base = {offset, 3'b000};
    assign ld_byte  = ld_data[bit_base +: 8];
    assign ld_half  = ld_data[bit_base +: 16];

    always_comb begin
        be       = '1;
        st_lanes = st_data;
        ld_ext   = ld_data;
        case (size)
            SZ_BYTE: begin
                be       = BE_W'(1) << offset;
                st_lanes = {BE_W{st_data[7:0]}};
                ld_ext   = {{(DATA_W-8){is_signed & ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                be       = BE_W'(3) << offset;
                st_lanes = {(BE_W/2){st_data[15:0]}};
                ld_ext   = {{(DATA_W-16){is_signed & ld_half[15]}}, ld_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access controller: one MFA/MFC handshake per byte/half/word/double transfer to RAM.
// Latency: RAM_REQ one edge after MFA, MFC one edge after the last beat (plus RAM wait cycles).
// Backpressure: each beat holds until RAM_RDY or the TIMEOUT budget expires; MFC holds until MFA drops.
`timescale 1ns/1ps
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                MFA,
    input  logic                RW,
    input  logic [1:0]          SIZE,
    input  logic                SIGNED,
    input  logic [ADDR_W-1:0]   ADDR,
    input  logic [2*DATA_W-1:0] WDATA,
    output logic [2*DATA_W-1:0] RDATA,
    output logic                MFC,
    output logic                FAULT,
    output logic                BUSY,
    output logic                RAM_REQ,
    output logic                RAM_WE,
    output logic [ADDR_W-1:0]   RAM_ADDR,
    output logic [DATA_W/8-1:0] RAM_BE,
    output logic [DATA_W-1:0]   RAM_WDATA,
    input  logic [DATA_W-1:0]   RAM_RDATA,
    input  logic                RAM_RDY
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t state, state_nxt;

    logic              req_rw, rw_nxt;
    logic [1:0]        req_size, size_nxt;
    logic              req_signed, sign_nxt;
    logic [OFF_W-1:0]  req_off, off_nxt;
    logic [DATA_W-1:0] req_whi, whi_nxt;
    logic [DATA_W-1:0] lo_q, lo_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;

    logic                req_nxt, we_nxt, mfc_nxt, fault_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [BYTES-1:0]    be_nxt;
    logic [DATA_W-1:0]   wdat_nxt;
    logic [2*DATA_W-1:0] rdata_nxt;

    logic              misaligned, beat_ok, to_hit;
    logic [ADDR_W-1:0] addr_aligned;
    logic [1:0]        st_size;
    logic              st_signed;
    logic [OFF_W-1:0]  st_off;
    logic [DATA_W-1:0] st_wdata, st_lanes, ld_ext;
    logic [BYTES-1:0]  st_be;

    assign misaligned   = |(ADDR & ADDR_W'(align_mask(SIZE, BYTES)));
    assign addr_aligned = {ADDR[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign beat_ok      = RAM_REQ & RAM_RDY;
    assign to_hit       = (TIMEOUT != 0) && RAM_REQ && !RAM_RDY && (cnt_q == CNT_W'(TO_M1));

    // In IDLE the first beat is steered straight from the live request; later beats use the latches.
    assign st_size   = (state == IDLE) ? SIZE   : req_size;
    assign st_signed = (state == IDLE) ? SIGNED : req_signed;
    assign st_off    = (state == IDLE) ? ADDR[OFF_W-1:0] : req_off;
    assign st_wdata  = (state == IDLE) ? WDATA[DATA_W-1:0] : req_whi;

    mem_lane_steer #(.DATA_W(DATA_W)) u_steer (
        .size      (st_size),
        .is_signed (st_signed),
        .offset    (st_off),
        .st_data   (st_wdata),
        .ld_data   (RAM_RDATA),
        .be        (st_be),
        .st_lanes  (st_lanes),
        .ld_ext    (ld_ext)
    );

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state      <= IDLE;
            RAM_REQ    <= 1'b0;
            RAM_WE     <= 1'b0;
            RAM_ADDR   <= '0;
            RAM_BE     <= '0;
            RAM_WDATA  <= '0;
            MFC        <= 1'b0;
            FAULT      <= 1'b0;
            BUSY       <= 1'b0;
            RDATA      <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            req_rw     <= 1'b0;
            req_size   <= SZ_BYTE;
            req_signed <= 1'b0;
            req_off    <= '0;
            req_whi    <= '0;
        end else begin
            state      <= state_nxt;
            RAM_REQ    <= req_nxt;
            RAM_WE     <= we_nxt;
            RAM_ADDR   <= addr_nxt;
            RAM_BE     <= be_nxt;
            RAM_WDATA  <= wdat_nxt;
            MFC        <= mfc_nxt;
            FAULT      <= fault_nxt;
            BUSY       <= (state_nxt != IDLE);
            RDATA      <= rdata_nxt;
            lo_q       <= lo_nxt;
            cnt_q      <= cnt_nxt;
            req_rw     <= rw_nxt;
            req_size   <= size_nxt;
            req_signed <= sign_nxt;
            req_off    <= off_nxt;
            req_whi    <= whi_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (MFA) state_nxt = misaligned ? DONE : BEAT0;
            BEAT0: begin
                if (beat_ok)     state_nxt = (req_size == SZ_DOUBLE) ? BEAT1 : DONE;
                else if (to_hit) state_nxt = DONE;
            end
            BEAT1: if (beat_ok || to_hit) state_nxt = DONE;
            DONE:  if (!MFA) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_nxt   = RAM_REQ;
        we_nxt    = RAM_WE;
        addr_nxt  = RAM_ADDR;
        be_nxt    = RAM_BE;
        wdat_nxt  = RAM_WDATA;
        mfc_nxt   = MFC;
        fault_nxt = FAULT;
        rdata_nxt = RDATA;
        lo_nxt    = lo_q;
        cnt_nxt   = cnt_q;
        rw_nxt    = req_rw;
        size_nxt  = req_size;
        sign_nxt  = req_signed;
        off_nxt   = req_off;
        whi_nxt   = req_whi;
        case (state)
            IDLE: if (MFA) begin
                rw_nxt   = RW;
                size_nxt = SIZE;
                sign_nxt = SIGNED;
                off_nxt  = ADDR[OFF_W-1:0];
                whi_nxt  = WDATA[2*DATA_W-1:DATA_W];
                cnt_nxt  = '0;
                if (misaligned) begin
                    mfc_nxt   = 1'b1;
                    fault_nxt = 1'b1;
                end else begin
                    req_nxt  = 1'b1;
                    we_nxt   = !RW;
                    addr_nxt = addr_aligned;
                    be_nxt   = st_be;
                    wdat_nxt = st_lanes;
                end
            end
            BEAT0, BEAT1: begin
                if (beat_ok) begin
                    cnt_nxt = '0;
                    if (state == BEAT0 && req_size == SZ_DOUBLE) begin
                        addr_nxt = RAM_ADDR + ADDR_W'(BYTES);
                        be_nxt   = st_be;
                        wdat_nxt = st_lanes;
                        lo_nxt   = RAM_RDATA;
                    end else begin
                        req_nxt = 1'b0;
                        we_nxt  = 1'b0;
                        mfc_nxt = 1'b1;
                        if (req_rw)
                            rdata_nxt = (state == BEAT1) ? {RAM_RDATA, lo_q}
                                                         : {{DATA_W{1'b0}}, ld_ext};
                    end
                end else if (to_hit) begin
                    req_nxt   = 1'b0;
                    we_nxt    = 1'b0;
                    mfc_nxt   = 1'b1;
                    fault_nxt = 1'b1;
                end else if (RAM_REQ) begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            DONE: if (!MFA) begin
                mfc_nxt   = 1'b0;
                fault_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (32-bit RAM, TIMEOUT=4) with hand-computed expectations.
`timescale 1ns/1ps
module tb_mem_access_unit;

    logic        CLK, CLR, MFA, RW, SIGNED, MFC, FAULT, BUSY, RAM_REQ, RAM_WE, RAM_RDY;
    logic [1:0]  SIZE;
    logic [31:0] ADDR, RAM_ADDR, RAM_WDATA, RAM_RDATA;
    logic [63:0] WDATA, RDATA;
    logic [3:0]  RAM_BE;

    int checks   = 0;
    int failures = 0;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .CLK(CLK), .CLR(CLR), .MFA(MFA), .RW(RW), .SIZE(SIZE), .SIGNED(SIGNED),
        .ADDR(ADDR), .WDATA(WDATA), .RDATA(RDATA), .MFC(MFC), .FAULT(FAULT), .BUSY(BUSY),
        .RAM_REQ(RAM_REQ), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_BE(RAM_BE),
        .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA), .RAM_RDY(RAM_RDY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic release_req();
        MFA = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        CLR = 1'b1; MFA = 0; RW = 0; SIZE = 0; SIGNED = 0; ADDR = 0; WDATA = 0;
        RAM_RDATA = 0; RAM_RDY = 0;
        tick(); tick();
        checks++; if ({MFC, FAULT, BUSY, RAM_REQ, RAM_WE} !== 5'b0) begin failures++;
            $display("FAIL reset_flags got=%b exp=00000", {MFC, FAULT, BUSY, RAM_REQ, RAM_WE}); end
        checks++; if ({RAM_ADDR, RAM_BE, RAM_WDATA} !== 68'h0) begin failures++;
            $display("FAIL reset_ram got=%h exp=0", {RAM_ADDR, RAM_BE, RAM_WDATA}); end
        checks++; if (RDATA !== 64'h0) begin failures++;
            $display("FAIL reset_rdata got=%h exp=0", RDATA); end
        CLR = 1'b0;
        tick();
    endtask

    task automatic test_byte_load();
        RAM_RDY = 1; RAM_RDATA = 32'h80FFFFFF;
        RW = 1; SIZE = 2'b00; SIGNED = 1; ADDR = 32'h103; MFA = 1;
        tick();
        checks++; if ({RAM_REQ, RAM_WE, BUSY, MFC} !== 4'b1010) begin failures++;
            $display("FAIL byte_req got=%b exp=1010", {RAM_REQ, RAM_WE, BUSY, MFC}); end
        checks++; if (RAM_BE !== 4'b1000) begin failures++;
            $display("FAIL byte_be got=%b exp=1000", RAM_BE); end
        checks++; if (RAM_ADDR !== 32'h100) begin failures++;
            $display("FAIL byte_addr got=%h exp=00000100", RAM_ADDR); end
        tick();
        checks++; if ({MFC, FAULT, RAM_REQ} !== 3'b100) begin failures++;
            $display("FAIL byte_done got=%b exp=100", {MFC, FAULT, RAM_REQ}); end
        checks++; if (RDATA !== 64'h00000000_FFFFFF80) begin failures++;
            $display("FAIL byte_rdata got=%h exp=00000000ffffff80", RDATA); end
        release_req();
        checks++; if ({MFC, BUSY} !== 2'b00) begin failures++;
            $display("FAIL byte_idle got=%b exp=00", {MFC, BUSY}); end
    endtask

    task automatic test_half_store();
        RW = 0; SIZE = 2'b01; SIGNED = 0; ADDR = 32'h202; WDATA = 64'hBEEF; MFA = 1;
        tick();
        checks++; if ({RAM_REQ, RAM_WE, RAM_BE} !== 6'b111100) begin failures++;
            $display("FAIL half_be got=%b exp=111100", {RAM_REQ, RAM_WE, RAM_BE}); end
        checks++; if (RAM_WDATA !== 32'hBEEFBEEF) begin failures++;
            $display("FAIL half_wdata got=%h exp=beefbeef", RAM_WDATA); end
        checks++; if (RAM_ADDR !== 32'h200) begin failures++;
            $display("FAIL half_addr got=%h exp=00000200", RAM_ADDR); end
        // MFA dropped mid-transfer and request inputs scrambled: must be ignored.
        MFA = 0; ADDR = 32'h3FF; WDATA = '1; SIZE = 2'b00; RW = 1;
        tick();
        checks++; if ({MFC, FAULT} !== 2'b10) begin failures++;
            $display("FAIL half_mfc got=%b exp=10", {MFC, FAULT}); end
        checks++; if (RDATA !== 64'h00000000_FFFFFF80) begin failures++;
            $display("FAIL half_rdata_kept got=%h exp=00000000ffffff80", RDATA); end
        tick();
        checks++; if ({MFC, BUSY} !== 2'b00) begin failures++;
            $display("FAIL half_pulse got=%b exp=00", {MFC, BUSY}); end
    endtask

    task automatic test_double_read();
        RAM_RDY = 0; RW = 1; SIZE = 2'b11; ADDR = 32'h1000; MFA = 1;
        tick();
        checks++; if ({RAM_REQ, RAM_BE, RAM_ADDR} !== {1'b1, 4'hF, 32'h1000}) begin failures++;
            $display("FAIL dbl_beat0 got=%b/%b/%h exp=1/1111/00001000", RAM_REQ, RAM_BE, RAM_ADDR); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({RAM_REQ, MFC, RAM_ADDR} !== {2'b10, 32'h1000}) begin failures++;
                $display("FAIL dbl_wait0 got=%b/%b/%h exp=1/0/00001000", RAM_REQ, MFC, RAM_ADDR); end
        end
        RAM_RDY = 1; RAM_RDATA = 32'h11223344;
        tick();
        checks++; if ({RAM_REQ, RAM_ADDR} !== {1'b1, 32'h1004}) begin failures++;
            $display("FAIL dbl_beat1 got=%b/%h exp=1/00001004", RAM_REQ, RAM_ADDR); end
        RAM_RDY = 0; RAM_RDATA = 32'hDEAD0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({RAM_REQ, MFC, RAM_ADDR} !== {2'b10, 32'h1004}) begin failures++;
                $display("FAIL dbl_wait1 got=%b/%b/%h exp=1/0/00001004", RAM_REQ, MFC, RAM_ADDR); end
        end
        RAM_RDY = 1; RAM_RDATA = 32'h55667788;
        tick();
        checks++; if ({MFC, FAULT, RAM_REQ} !== 3'b100) begin failures++;
            $display("FAIL dbl_done got=%b exp=100", {MFC, FAULT, RAM_REQ}); end
        checks++; if (RDATA !== 64'h55667788_11223344) begin failures++;
            $display("FAIL dbl_rdata got=%h exp=5566778811223344", RDATA); end
        release_req();
    endtask

    task automatic test_extension();
        logic [1:0]  t_size [3] = '{2'b00, 2'b01, 2'b01};
        logic        t_sgn  [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] t_addr [3] = '{32'h101, 32'h2, 32'h0};
        logic [31:0] t_ram  [3] = '{32'h12345678, 32'h80FF1234, 32'h0000F00D};
        logic [63:0] t_exp  [3] = '{64'h56, 64'hFFFF80FF, 64'hF00D};
        for (int i = 0; i < 3; i++) begin
            RAM_RDY = 1; RAM_RDATA = t_ram[i];
            RW = 1; SIZE = t_size[i]; SIGNED = t_sgn[i]; ADDR = t_addr[i]; MFA = 1;
            tick(); tick();
            checks++; if ({MFC, RDATA} !== {1'b1, t_exp[i]}) begin failures++;
                $display("FAIL ext_%0d got=%b/%h exp=1/%h", i, MFC, RDATA, t_exp[i]); end
            release_req();
        end
    endtask

    task automatic test_misaligned();
        logic [1:0]  t_size [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] t_addr [3] = '{32'h2, 32'h1, 32'h4};
        for (int i = 0; i < 3; i++) begin
            RAM_RDY = 1; RW = 1; SIZE = t_size[i]; ADDR = t_addr[i]; MFA = 1;
            tick();
            checks++; if ({MFC, FAULT, RAM_REQ} !== 3'b110) begin failures++;
                $display("FAIL misal_%0d got=%b exp=110", i, {MFC, FAULT, RAM_REQ}); end
            if (i == 0) begin
                tick(); tick();
                checks++; if ({MFC, FAULT, RAM_REQ} !== 3'b110) begin failures++;
                    $display("FAIL misal_hold got=%b exp=110", {MFC, FAULT, RAM_REQ}); end
            end
            release_req();
            checks++; if ({MFC, FAULT, BUSY} !== 3'b000) begin failures++;
                $display("FAIL misal_clear_%0d got=%b exp=000", i, {MFC, FAULT, BUSY}); end
        end
        checks++; if (RDATA !== 64'hF00D) begin failures++;
            $display("FAIL misal_rdata_kept got=%h exp=000000000000f00d", RDATA); end
    endtask

    task automatic test_timeout();
        int hi = 0;
        RAM_RDY = 0; RW = 1; SIZE = 2'b10; ADDR = 32'h300; MFA = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (RAM_REQ) hi++;
        end
        checks++; if (hi !== 4) begin failures++;
            $display("FAIL to_req_cycles got=%0d exp=4", hi); end
        checks++; if ({MFC, FAULT, RAM_REQ} !== 3'b110) begin failures++;
            $display("FAIL to_fault got=%b exp=110", {MFC, FAULT, RAM_REQ}); end
        release_req();
        // Double read: beat 0 succeeds, beat 1 times out; RDATA must be untouched.
        RAM_RDY = 1; RAM_RDATA = 32'hAAAAAAAA; SIZE = 2'b11; ADDR = 32'h400; MFA = 1;
        tick(); tick();
        RAM_RDY = 0;
        checks++; if ({RAM_REQ, RAM_ADDR} !== {1'b1, 32'h404}) begin failures++;
            $display("FAIL to_dbl_beat1 got=%b/%h exp=1/00000404", RAM_REQ, RAM_ADDR); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if ({MFC, FAULT, RDATA} !== {2'b11, 64'hF00D}) begin failures++;
            $display("FAIL to_dbl_partial got=%b%b/%h exp=11/000000000000f00d", MFC, FAULT, RDATA); end
        release_req();
    endtask

    task automatic test_clr_abort();
        RAM_RDY = 1; RW = 0; SIZE = 2'b11; ADDR = 32'h2000; WDATA = 64'hCAFEBABE_DEADBEEF; MFA = 1;
        tick();
        checks++; if ({RAM_WE, RAM_WDATA} !== {1'b1, 32'hDEADBEEF}) begin failures++;
            $display("FAIL clr_beat0 got=%b/%h exp=1/deadbeef", RAM_WE, RAM_WDATA); end
        tick();
        checks++; if ({RAM_REQ, RAM_ADDR, RAM_WDATA} !== {1'b1, 32'h2004, 32'hCAFEBABE}) begin failures++;
            $display("FAIL clr_beat1 got=%b/%h/%h exp=1/00002004/cafebabe", RAM_REQ, RAM_ADDR, RAM_WDATA); end
        #2 CLR = 1'b1;
        #1;
        checks++; if ({RAM_REQ, BUSY, MFC} !== 3'b000) begin failures++;
            $display("FAIL clr_async got=%b exp=000", {RAM_REQ, BUSY, MFC}); end
        #1 CLR = 1'b0; MFA = 0;
        tick();
        RAM_RDATA = 32'h0BADF00D; RW = 1; SIZE = 2'b10; ADDR = 32'h40; MFA = 1;
        tick();
        checks++; if ({RAM_REQ, RAM_ADDR} !== {1'b1, 32'h40}) begin failures++;
            $display("FAIL clr_next_req got=%b/%h exp=1/00000040", RAM_REQ, RAM_ADDR); end
        tick();
        checks++; if ({MFC, FAULT, RDATA} !== {2'b10, 64'h0BADF00D}) begin failures++;
            $display("FAIL clr_next_done got=%b%b/%h exp=10/000000000badf00d", MFC, FAULT, RDATA); end
        release_req();
        checks++; if (BUSY !== 1'b0) begin failures++;
            $display("FAIL clr_next_idle got=%b exp=0", BUSY); end
    endtask

    initial begin
        test_reset();
        test_byte_load();
        test_half_store();
        test_double_read();
        test_extension();
        test_misaligned();
        test_timeout();
        test_clr_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-access controller between the datapath (MAR/MDR, control unit) and the RAM. It accepts one request per MFA/MFC four-phase handshake and performs byte, halfword, word or two-beat doubleword transfers with little-endian lane steering and sign/zero extension of loads. It also handles misalignment and RAM-timeout faults. It supersedes direct RAM wiring with a variable-latency RAM port.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, RAM data width; multiple of 8, power of two ≥ 16
- TIMEOUT, 64, max cycles waiting for RAM_RDY per beat; 0 disables timeout

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  clock, rising edge
- CLR  in  1  asynchronous active-high reset
- MFA  in  1  memory function active (request), level
- RW  in  1  1 = read, 0 = write
- SIZE  in  2  00 byte, 01 half, 10 word (DATA_W), 11 double (2×DATA_W)
- SIGNED  in  1  sign-extend byte/half loads
- ADDR  in  ADDR_W  byte address
- WDATA  in  2×DATA_W  store data, right-justified
- RDATA  out  2×DATA_W  load result
- MFC  out  1  memory function complete
- FAULT  out  1  valid while MFC=1; misaligned or timeout
- BUSY  out  1  high in any state other than IDLE
- RAM_REQ  out  1  beat request
- RAM_WE  out  1  beat is a write
- RAM_ADDR  out  ADDR_W  beat byte address, DATA_W/8-aligned
- RAM_BE  out  DATA_W/8  byte enables
- RAM_WDATA  out  DATA_W  steered store data
- RAM_RDATA  in  DATA_W  read data, valid with RAM_RDY
- RAM_RDY  in  1  beat complete when RAM_REQ & RAM_RDY at a rising edge

## Operation
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE: MFA=1 at an edge latches RW/SIZE/SIGNED/ADDR/WDATA. Later changes to these inputs are ignored until the next IDLE.
  - Misaligned request goes to DONE with FAULT=1 and no RAM beat. Alignment: half 2 B, word DATA_W/8 B, double 2×DATA_W/8 B.
  - Otherwise go to BEAT0.
- BEAT0/BEAT1: RAM_REQ=1 and RAM_WE=!RW. Outputs stay stable until the beat completes.
  - BEAT1 address = BEAT0 address + DATA_W/8.
  - After BEAT0 completes: SIZE=11 goes to BEAT1; all other sizes go to DONE.
  - After BEAT1 completes, go to DONE.
- Lane steering, offset n = ADDR[log2(DATA_W/8)-1:0]:
  - Byte: RAM_BE bit n; WDATA[7:0] replicated on all lanes.
  - Half: BE bits n, n+1; WDATA[15:0] replicated.
  - Word/double: all BE set.
- Load result:
  - Byte/half: the selected lanes are extended (SIGNED) to DATA_W in RDATA[DATA_W-1:0]; the upper half is 0.
  - Word: upper half 0.
  - Double: beat 0 goes to the low half, beat 1 to the high half.
- Timeout: a counter clears at each beat start and increments each cycle RAM_REQ=1 & RAM_RDY=0. When it reaches TIMEOUT, RAM_REQ drops and the unit goes to DONE with FAULT=1. A partial double read leaves RDATA unchanged.
- DONE: MFC=1. Stays in DONE while MFA=1; returns to IDLE on the first edge with MFA=0, clearing MFC and FAULT.
- MFA dropped mid-transfer: the transfer completes and MFC pulses for exactly one cycle.
- RDATA updates only on a successful read completion; writes and faults leave it unchanged.

## Timing
- Reset values: MFC=0, FAULT=0, BUSY=0, RAM_REQ=0, RAM_WE=0, RAM_ADDR=0, RAM_BE=0, RAM_WDATA=0, RDATA=0; state IDLE; counter 0.
- All outputs are registered. CLR aborts any beat immediately, with RAM_REQ falling asynchronously.
- Latency with RAM_RDY tied high:
  - MFA sampled at edge E; RAM_REQ high after E.
  - Single beat completes at E+1; MFC high after E+1.
  - Double beat completes at E+2; MFC high after E+2.
- Each RAM wait cycle adds one cycle.
- Misaligned request: MFC and FAULT high after E.
- A new request can be accepted no earlier than the edge after MFC falls.

## Structure
- Package mem_access_pkg: SIZE encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE), the state enum, and the alignment-mask function.
- Sub-module mem_lane_steer (combinational): store replication, BE generation, load extraction and extension.
- Top level holds the FSM, timeout counter, request latches and RDATA register.

## Test plan
- Signed byte load at ADDR=0x103, RAM_RDATA=0x80FFFFFF, RDY tied 1 → RAM_BE=1000, RDATA=0x00000000_FFFFFF80, MFC 2 cycles after MFA, FAULT=0.
- Unsigned half store at ADDR=0x202 with WDATA=0xBEEF → RAM_WE=1, RAM_BE=1100, RAM_WDATA=0xBEEFBEEF, RAM_ADDR=0x200; RDATA unchanged.
- Double read at 0x1000, RDY low 3 cycles per beat → RAM_ADDR 0x1000 then 0x1004, RDATA={beat1,beat0}, MFC after 2+6 cycles.
- Word read at ADDR=0x2 → no RAM_REQ, MFC=FAULT=1 one cycle after MFA, held until MFA falls.
- RDY never asserted, TIMEOUT=4 → RAM_REQ high 4 cycles, then MFC=FAULT=1.
- CLR pulsed during BEAT1 of a double write → RAM_REQ=0 immediately, BUSY=0, next request serviced normally.
